sc_bitstream_decoder: RTL

SC_BITSTREAM_DECODER -- requirements
Module: sc_bitstream_decoder

---
 rtl/sc_bitstream_decoder.sv | 99 +++++++++
 1 files changed

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^LOG_LEN
// valid bits and reports the total with a one-cycle done pulse.
module sc_bitstream_decoder #(
    parameter int LOG_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             busy,
    output logic             done,
    output logic [LOG_LEN:0] count
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam logic [LOG_LEN-1:0] BIT_ONE = 1;

    state_t             state;
    state_t             state_n;
    logic [LOG_LEN:0]   acc;
    logic [LOG_LEN:0]   acc_n;
    logic [LOG_LEN:0]   count_n;
    logic [LOG_LEN:0]   sum;
    logic [LOG_LEN-1:0] bits;
    logic [LOG_LEN-1:0] bits_n;
    logic               done_n;
    logic               last;

    assign sum  = acc + {{LOG_LEN{1'b0}}, in_bit};
    // bits holds the number already sampled, so all-ones means
    // the bit arriving now completes the window.
    assign last = &bits;
    assign busy = (state == COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            bits  <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            bits  <= bits_n;
            count <= count_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        bits_n  = bits;
        count_n = count;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = COUNT;
                    acc_n   = '0;
                    bits_n  = '0;
                end
            end
            COUNT: begin
                unique case (1'b1)
                    abort: begin
                        state_n = IDLE;
                    end
                    (!abort && in_valid && last): begin
                        state_n = IDLE;
                        count_n = sum;
                        done_n  = 1'b1;
                    end
                    (!abort && in_valid && !last): begin
                        acc_n  = sum;
                        bits_n = bits + BIT_ONE;
                    end
                    (!abort && !in_valid): begin
                        state_n = COUNT;
                    end
                    default: begin
                        state_n = state;
                    end
                endcase
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
